// File: rtl/player_motion_ctrl.sv
// Player movement sequencer: on each move tick, queries the maze detector when tile-centred,
// chooses a heading, then steps the display position with horizontal tunnel wrap-around.
module player_motion_ctrl #(
  parameter int unsigned ORIGIN_X = 336,
  parameter int unsigned ORIGIN_Y = 27,
  parameter int unsigned TILE     = 16,
  parameter int unsigned CENTER   = 7,
  parameter int unsigned COLS     = 80,
  parameter int unsigned STEP     = 1,
  parameter int unsigned DET_LAT  = 1,
  parameter int unsigned START_X  = 551,
  parameter int unsigned START_Y  = 114
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        move_tick,
  input  logic [3:0]  dir_req,
  input  logic [3:0]  valid_moves,
  output logic [10:0] q_pos_x,
  output logic [9:0]  q_pos_y,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [3:0]  cur_dir,
  output logic        moving,
  output logic        busy,
  output logic        tick_ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_QUERY  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [1:0] S_STEP   = 2'd3;

  localparam int unsigned WW = (DET_LAT > 1) ? $clog2(DET_LAT) : 1;

  localparam logic [11:0]   X_MIN     = 12'(ORIGIN_X + CENTER);
  localparam logic [11:0]   X_MAX     = 12'(ORIGIN_X + CENTER + (COLS - 1) * TILE);
  localparam logic [11:0]   Y_MIN     = 12'(ORIGIN_Y + CENTER);
  localparam logic [11:0]   T_MASK    = 12'(TILE - 1);
  localparam logic [11:0]   STEP_W    = 12'(STEP);
  localparam logic [WW-1:0] WAIT_LOAD = WW'(DET_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic [10:0]   pos_x_q, pos_x_d, q_x_q, q_x_d;
  logic [9:0]    pos_y_q, pos_y_d, q_y_q, q_y_d;
  logic [3:0]    dir_q, dir_d;
  logic [3:0]    req_lat_q, req_lat_d;
  logic          moving_q, moving_d;
  logic          pending_q, pending_d;
  logic          ovf_q, ovf_d;
  logic [WW-1:0] wait_q, wait_d;

  logic [11:0] px, py;
  logic [3:0]  req_now, req_eff, dir_rev;
  logic        centred;

  // The tick being accepted in IDLE uses its own dir_req, not the stale latch.
  always_comb begin
    px      = {1'b0, pos_x_q};
    py      = {2'b00, pos_y_q};
    req_now = $onehot(dir_req) ? dir_req : '0;
    req_eff = move_tick ? req_now : req_lat_q;
    dir_rev = {dir_q[1:0], dir_q[3:2]};
    centred = (((px - X_MIN) & T_MASK) == '0) && (((py - Y_MIN) & T_MASK) == '0);
  end

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    q_x_d     = q_x_q;
    q_y_d     = q_y_q;
    dir_d     = dir_q;
    moving_d  = moving_q;
    pending_d = pending_q;
    ovf_d     = ovf_q;
    wait_d    = wait_q;
    req_lat_d = move_tick ? req_now : req_lat_q;

    case (state_q)
      S_IDLE: begin
        if (move_tick || pending_q) begin
          pending_d = pending_q && move_tick;
          if (centred) begin
            q_x_d   = pos_x_q;
            q_y_d   = pos_y_q;
            wait_d  = WAIT_LOAD;
            state_d = S_QUERY;
          end else begin
            if (req_eff == dir_rev) dir_d = req_eff;
            state_d = S_STEP;
          end
        end
      end
      S_QUERY: begin
        if (wait_q == '0) state_d = S_DECIDE;
        else              wait_d  = wait_q - 1'b1;
      end
      S_DECIDE: begin
        if ((req_lat_q & valid_moves) != '0) begin
          dir_d   = req_lat_q;
          state_d = S_STEP;
        end else if ((dir_q & valid_moves) != '0) begin
          state_d = S_STEP;
        end else begin
          moving_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      S_STEP: begin
        moving_d = 1'b1;
        state_d  = S_IDLE;
        if (dir_q[0])      pos_x_d = (px == X_MAX) ? X_MIN[10:0] : 11'(px + STEP_W);
        else if (dir_q[2]) pos_x_d = (px == X_MIN) ? X_MAX[10:0] : 11'(px - STEP_W);
        else if (dir_q[1]) pos_y_d = 10'(py - STEP_W);
        else if (dir_q[3]) pos_y_d = 10'(py + STEP_W);
      end
    endcase

    // One tick may wait while busy; any further one is dropped and flagged.
    if (move_tick && (state_q != S_IDLE)) begin
      if (pending_q) ovf_d     = 1'b1;
      else           pending_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pos_x_q   <= 11'(START_X);
      pos_y_q   <= 10'(START_Y);
      q_x_q     <= 11'(START_X);
      q_y_q     <= 10'(START_Y);
      dir_q     <= 4'b0001;
      req_lat_q <= '0;
      moving_q  <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      q_x_q     <= q_x_d;
      q_y_q     <= q_y_d;
      dir_q     <= dir_d;
      req_lat_q <= req_lat_d;
      moving_q  <= moving_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      wait_q    <= wait_d;
    end
  end

  assign q_pos_x  = q_x_q;
  assign q_pos_y  = q_y_q;
  assign pos_x    = pos_x_q;
  assign pos_y    = pos_y_q;
  assign cur_dir  = dir_q;
  assign moving   = moving_q;
  assign busy     = (state_q != S_IDLE);
  assign tick_ovf = ovf_q;

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: random joystick/maze stimulus against a
// tile-level movement model, plus tunnel wrap, tick overflow and mid-query reset scenarios.
module tb_player_motion_ctrl;

  localparam int DL   = 4;
  localparam int X0   = 343;
  localparam int Y0   = 34;
  localparam int XMAX = 1607;
  localparam int ROWS = 28;
  localparam int SX   = 551;
  localparam int SY   = 114;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        move_tick = 1'b0;
  logic [3:0]  dir_req = 4'b0000;
  logic [3:0]  valid_moves;
  logic [10:0] q_pos_x;
  logic [9:0]  q_pos_y;
  logic [10:0] pos_x;
  logic [9:0]  pos_y;
  logic [3:0]  cur_dir;
  logic        moving, busy, tick_ovf;

  player_motion_ctrl #(.DET_LAT(DL)) dut (
    .clk(clk), .rst_n(rst_n), .move_tick(move_tick), .dir_req(dir_req),
    .valid_moves(valid_moves), .q_pos_x(q_pos_x), .q_pos_y(q_pos_y),
    .pos_x(pos_x), .pos_y(pos_y), .cur_dir(cur_dir), .moving(moving),
    .busy(busy), .tick_ovf(tick_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Maze: mode 0 all open, mode 1 random per-tile table, mode 2 horizontal corridor.
  int mode = 0;
  logic [3:0] tbl [0:79][0:ROWS-1];

  function automatic logic [3:0] maze(input int x, input int y);
    int c, r;
    logic [3:0] b;
    if (x < X0 || x > XMAX || y < Y0) return 4'b0000;
    c = (x - X0) / 16;
    r = (y - Y0) / 16;
    if (r >= ROWS) return 4'b0000;
    case (mode)
      0:       b = 4'b1111;
      1:       b = tbl[c][r];
      default: b = 4'b0101;
    endcase
    if (r == 0)        b[1] = 1'b0;
    if (r == ROWS - 1) b[3] = 1'b0;
    return b;
  endfunction

  logic [3:0] pipe [DL];
  always @(posedge clk) begin
    pipe[0] <= maze(int'(q_pos_x), int'(q_pos_y));
    for (int i = 1; i < DL; i++) pipe[i] <= pipe[i-1];
  end
  assign valid_moves = pipe[DL-1];

  // Reference model: player state in pixels, decisions by tile rules.
  int mx, my, mqx, mqy, mmv;
  logic [3:0] mdir;

  task automatic model_reset();
    mx = SX; my = SY; mqx = SX; mqy = SY; mdir = 4'b0001; mmv = 0;
  endtask

  function automatic logic [3:0] opposite(input logic [3:0] d);
    case (d)
      4'b0001: return 4'b0100;
      4'b0100: return 4'b0001;
      4'b0010: return 4'b1000;
      4'b1000: return 4'b0010;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_tick(input logic [3:0] raw, output int lat);
    logic [3:0] req, v;
    req = $onehot(raw) ? raw : 4'b0000;
    lat = 2;
    if ((mx - X0) % 16 == 0 && (my - Y0) % 16 == 0) begin
      mqx = mx; mqy = my;
      v = maze(mx, my);
      lat = DL + 3;
      if ((req & v) != 0) mdir = req;
      else if ((mdir & v) == 0) begin
        mmv = 0;
        lat = DL + 2;
        return;
      end
    end else if (req != 0 && req == opposite(mdir)) begin
      mdir = req;
    end
    case (mdir)
      4'b0001: mx = (mx == XMAX) ? X0 : mx + 1;
      4'b0100: mx = (mx == X0) ? XMAX : mx - 1;
      4'b0010: my = my - 1;
      default: my = my + 1;
    endcase
    mmv = 1;
  endtask

  typedef struct {
    int x; int y; int qx; int qy; int dir; int mv; int lat; int t0;
  } exp_t;
  exp_t sb[$];

  task automatic push_expect(input int lat);
    exp_t e;
    e.x = mx; e.y = my; e.qx = mqx; e.qy = mqy; e.dir = int'(mdir); e.mv = mmv;
    e.lat = lat; e.t0 = cyc + 1;
    sb.push_back(e);
  endtask

  // Monitor: each end of a busy period is one completed tick.
  logic busy_prev = 1'b0;
  exp_t me;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_prev = 1'b0;
    end else begin
      if (busy_prev && !busy) begin
        if (sb.size() == 0) begin
          chk("unexpected_done_queue", sb.size(), 1);
        end else begin
          me = sb.pop_front();
          chk("pos_x", int'(pos_x), me.x);
          chk("pos_y", int'(pos_y), me.y);
          chk("q_pos_x", int'(q_pos_x), me.qx);
          chk("q_pos_y", int'(q_pos_y), me.qy);
          chk("cur_dir", int'(cur_dir), me.dir);
          chk("moving", int'(moving), me.mv);
          if (me.lat >= 0) chk("latency", cyc - me.t0 + 1, me.lat);
        end
      end
      busy_prev = busy;
    end
  end

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("done_timeout_queue", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic do_tick(input logic [3:0] raw);
    int lat;
    model_tick(raw, lat);
    push_expect(lat);
    move_tick = 1'b1;
    dir_req   = raw;
    @(negedge clk);
    move_tick = 1'b0;
    dir_req   = 4'($urandom);
    wait_drain(40);
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_pos_x"}, int'(pos_x), SX);
    chk({tag, "_pos_y"}, int'(pos_y), SY);
    chk({tag, "_q_pos_x"}, int'(q_pos_x), SX);
    chk({tag, "_q_pos_y"}, int'(q_pos_y), SY);
    chk({tag, "_cur_dir"}, int'(cur_dir), 1);
    chk({tag, "_moving"}, int'(moving), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_tick_ovf"}, int'(tick_ovf), 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    model_reset();
    repeat (DL + 1) @(negedge clk);
  endtask

  function automatic logic [3:0] rand_req();
    case ($urandom_range(0, 5))
      0:       return 4'b0001;
      1:       return 4'b0010;
      2:       return 4'b0100;
      3:       return 4'b1000;
      4:       return 4'b0000;
      default: return 4'($urandom);
    endcase
  endfunction

  initial begin
    #3_000_000;
    $display("FAIL watchdog_timeout cycles=%0d", cyc);
    $fatal(1);
  end

  initial begin
    int lat, n;
    for (int c = 0; c < 80; c++)
      for (int r = 0; r < ROWS; r++)
        tbl[c][r] = 4'($urandom);
    model_reset();
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rst_n = 1'b1;
    repeat (DL + 1) @(negedge clk);

    // Centred start, all open, request right.
    mode = 0;
    do_tick(4'b0001);
    do_tick(4'b0010);

    // Random walk over a random maze.
    mode = 1;
    repeat (DL + 2) @(negedge clk);
    repeat (300) do_tick(rand_req());

    // Corridor: run right through the tunnel, reverse mid-tile, run left through it.
    mode = 2;
    repeat (DL + 2) @(negedge clk);
    n = 0;
    while (!(mx == X0 + 3 && mdir == 4'b0001) && n < 1500) begin
      do_tick(4'b0001);
      n++;
    end
    n = 0;
    do_tick(4'b0100);
    while (mx != XMAX && n < 40) begin
      do_tick(4'b0100);
      n++;
    end
    do_tick(4'b0000);

    // Three back-to-back ticks: second waits, third overflows.
    mode = 0;
    reset_pulse();
    model_tick(4'b0001, lat);
    push_expect(lat);
    move_tick = 1'b1;
    dir_req   = 4'b0001;
    @(negedge clk);
    model_tick(4'b0001, lat);
    push_expect(-1);
    @(negedge clk);
    @(negedge clk);
    move_tick = 1'b0;
    wait_drain(60);
    chk("tick_ovf_set", int'(tick_ovf), 1);
    repeat (14) do_tick(4'b0001);
    chk("tick_ovf_sticky", int'(tick_ovf), 1);

    // Reset in the middle of a query aborts it.
    move_tick = 1'b1;
    dir_req   = 4'b0001;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    chk("busy_in_query", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1 reset_checks("midquery_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (DL + 4) @(negedge clk);
    chk("no_step_after_abort_x", int'(pos_x), SX);
    chk("no_step_after_abort_busy", int'(busy), 0);

    mode = 1;
    repeat (DL + 2) @(negedge clk);
    repeat (20) do_tick(rand_req());

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
